// File: rtl/score_digit_renderer_pkg.sv
// Shared constants and types for the two-digit score overlay.
package score_digit_renderer_pkg;

    localparam int unsigned DIGIT_W     = 32;
    localparam int unsigned DIGIT_H     = 32;
    localparam logic [11:0] TRANSPARENT = 12'hFFF;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/score_digit_renderer_bcd_counter2.sv
// Two-digit BCD score counter with decimal carry and sticky wrap flag.
module bcd_counter2
    import score_digit_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    output bcd_digit_t ones,
    output bcd_digit_t tens,
    output logic       overflow
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ones     <= '0;
            tens     <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            ones     <= '0;
            tens     <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (ones == 4'd9) begin
                ones <= '0;
                if (tens == 4'd9) begin
                    tens     <= '0;
                    overflow <= 1'b1;
                end else begin
                    tens <= tens + 4'd1;
                end
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/score_digit_renderer.sv
// Score overlay: BCD score, frame-latched display copy, and a two-stage
// compositor that blends digit ROM pixels over the background.
module score_digit_renderer
    import score_digit_renderer_pkg::*;
#(
    parameter logic [9:0] X0 = 10'd288,
    parameter logic [9:0] Y0 = 10'd16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        inc,
    input  logic        clr,
    input  logic [11:0] rgb_bg,
    output logic [3:0]  rom_digit,
    output logic [4:0]  rom_row,
    output logic [4:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb_out,
    output logic [7:0]  score_bcd,
    output logic        overflow
);

    localparam logic [10:0] BOX_W = 11'(DIGIT_W);
    localparam logic [10:0] BOX_H = 11'(DIGIT_H);

    bcd_digit_t live_ones;
    bcd_digit_t live_tens;
    bcd_digit_t disp_ones;
    bcd_digit_t disp_tens;

    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] x0_ext;
    logic [10:0] y0_ext;
    logic        in_rows;
    logic        in_tens;
    logic        in_ones;
    logic        hit;
    logic        blank_lead;

    logic        s1_hit;
    logic        s1_blank;
    logic        s1_video_on;
    logic [11:0] s1_bg;

    bcd_counter2 u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc      (inc),
        .clr      (clr),
        .ones     (live_ones),
        .tens     (live_tens),
        .overflow (overflow)
    );

    assign score_bcd = {live_tens, live_ones};

    // Sampling before the counter edge gives the pre-increment value on a shared cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_ones <= '0;
            disp_tens <= '0;
        end else if (frame_tick) begin
            disp_ones <= live_ones;
            disp_tens <= live_tens;
        end
    end

    // Compare in 11 bits so positions left of / above the field never alias into it.
    assign px      = {1'b0, pixel_x};
    assign py      = {1'b0, pixel_y};
    assign x0_ext  = {1'b0, X0};
    assign y0_ext  = {1'b0, Y0};
    assign in_rows = (py >= y0_ext) && (py < y0_ext + BOX_H);
    assign in_tens = in_rows && (px >= x0_ext) && (px < x0_ext + BOX_W);
    assign in_ones = in_rows && (px >= x0_ext + BOX_W) && (px < x0_ext + (BOX_W << 1));
    assign hit     = in_tens || in_ones;

    assign blank_lead = in_tens && (disp_tens == 4'd0);

    // Digit boxes are 32 wide/high, so the low five bits of the offset are the address.
    assign rom_row = pixel_y[4:0] - Y0[4:0];
    assign rom_col = pixel_x[4:0] - X0[4:0];

    always_comb begin
        rom_digit = '0;
        if (in_tens) begin
            rom_digit = disp_tens;
        end else if (in_ones) begin
            rom_digit = disp_ones;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_hit      <= 1'b0;
            s1_blank    <= 1'b0;
            s1_video_on <= 1'b0;
            s1_bg       <= '0;
        end else begin
            s1_hit      <= hit;
            s1_blank    <= blank_lead;
            s1_video_on <= video_on;
            s1_bg       <= rgb_bg;
        end
    end

    // rom_color here belongs to the pixel now held in stage 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out <= '0;
        end else if (!s1_video_on) begin
            rgb_out <= '0;
        end else if (!s1_hit || s1_blank || (rom_color == TRANSPARENT)) begin
            rgb_out <= s1_bg;
        end else begin
            rgb_out <= rom_color;
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Randomized self-checking bench for score_digit_renderer with a behavioural model.
module tb_score_digit_renderer;

    localparam int X0 = 288;
    localparam int Y0 = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        frame_tick;
    logic        inc;
    logic        clr;
    logic [11:0] rgb_bg;
    logic [3:0]  rom_digit;
    logic [4:0]  rom_row;
    logic [4:0]  rom_col;
    logic [11:0] rom_color;
    logic [11:0] rgb_out;
    logic [7:0]  score_bcd;
    logic        overflow;

    always #5 clk = ~clk;

    score_digit_renderer #(
        .X0 (10'(X0)),
        .Y0 (10'(Y0))
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .inc        (inc),
        .clr        (clr),
        .rgb_bg     (rgb_bg),
        .rom_digit  (rom_digit),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_color  (rom_color),
        .rgb_out    (rgb_out),
        .score_bcd  (score_bcd),
        .overflow   (overflow)
    );

    typedef struct {
        bit          hit;
        bit          blank;
        bit          von;
        logic [11:0] bg;
    } pix_t;

    int   total = 0;
    int   bad   = 0;
    int   m_score;
    int   m_disp;
    bit   m_ovf;
    pix_t m_prev;
    logic [11:0] m_rgb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_tens_box(input int x, input int y);
        return (y >= Y0) && (y < Y0 + 32) && (x >= X0) && (x < X0 + 32);
    endfunction

    function automatic bit in_ones_box(input int x, input int y);
        return (y >= Y0) && (y < Y0 + 32) && (x >= X0 + 32) && (x < X0 + 64);
    endfunction

    function automatic int exp_digit(input int x, input int y, input int disp);
        if (in_tens_box(x, y)) return disp / 10;
        if (in_ones_box(x, y)) return disp % 10;
        return 0;
    endfunction

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic model_reset();
        m_score = 0;
        m_disp  = 0;
        m_ovf   = 1'b0;
        m_prev  = '{hit: 1'b0, blank: 1'b0, von: 1'b0, bg: 12'h000};
        m_rgb   = 12'h000;
    endtask

    // Check all outputs at the falling edge, then advance the model across the rising edge.
    task automatic step();
        int   x;
        int   y;
        pix_t cur;
        @(negedge clk);
        x = int'(pixel_x);
        y = int'(pixel_y);
        chk("rom_row",   rom_row,   (y - Y0) & 31);
        chk("rom_col",   rom_col,   (x - X0) & 31);
        chk("rom_digit", rom_digit, exp_digit(x, y, m_disp));
        chk("score_bcd", score_bcd, to_bcd(m_score));
        chk("overflow",  overflow,  m_ovf);
        chk("rgb_out",   rgb_out,   m_rgb);
        @(posedge clk);
        #1;
        if (reset_n) begin
            cur.hit   = in_tens_box(x, y) || in_ones_box(x, y);
            cur.blank = in_tens_box(x, y) && (m_disp / 10 == 0);
            cur.von   = video_on;
            cur.bg    = rgb_bg;
            if (!m_prev.von)
                m_rgb = 12'h000;
            else if (!m_prev.hit || m_prev.blank || rom_color == 12'hFFF)
                m_rgb = m_prev.bg;
            else
                m_rgb = rom_color;
            m_prev = cur;
            if (frame_tick) m_disp = m_score;
            if (clr) begin
                m_score = 0;
                m_ovf   = 1'b0;
            end else if (inc) begin
                if (m_score == 99) begin
                    m_score = 0;
                    m_ovf   = 1'b1;
                end else begin
                    m_score = m_score + 1;
                end
            end
        end
    endtask

    task automatic cyc(input int x, input int y, input bit von, input logic [11:0] bg,
                       input logic [11:0] rom, input bit i, input bit c, input bit f);
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        video_on   = von;
        rgb_bg     = bg;
        rom_color  = rom;
        inc        = i;
        clr        = c;
        frame_tick = f;
        step();
        inc        = 1'b0;
        clr        = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        video_on   = 1'b0;
        frame_tick = 1'b0;
        inc        = 1'b0;
        clr        = 1'b0;
        rgb_bg     = '0;
        rom_color  = '0;
        model_reset();

        repeat (3) cyc(X0 + 5, Y0 + 5, 1'b1, 12'hABC, 12'h0F0, 1'b1, 1'b0, 1'b1);
        chk("reset_rgb",   rgb_out,   12'h000);
        chk("reset_score", score_bcd, 8'h00);
        chk("reset_ovf",   overflow,  1'b0);
        reset_n = 1'b1;

        // Eleven increments, display only follows after the frame tick
        repeat (11) cyc(X0 + 5, Y0 + 5, 1'b1, 12'h111, 12'h0F0, 1'b1, 1'b0, 1'b0);
        chk("inc11_score", score_bcd, 8'h11);
        chk("inc11_model", m_score, 11);
        chk("inc11_disp_pre", rom_digit, 4'd0);
        cyc(X0 + 5, Y0 + 5, 1'b1, 12'h111, 12'h0F0, 1'b0, 1'b0, 1'b1);
        chk("inc11_disp_tens", rom_digit, 4'd1);
        pixel_x = 10'(X0 + 40);
        #1;
        chk("inc11_disp_ones", rom_digit, 4'd1);

        // Wrap 99 -> 00 and clear priority
        cyc(0, 0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0);
        repeat (99) cyc(0, 0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("at99_score", score_bcd, 8'h99);
        cyc(0, 0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
        chk("wrap_score", score_bcd, 8'h00);
        chk("wrap_ovf",   overflow,  1'b1);
        cyc(0, 0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0);
        chk("clrinc_score", score_bcd, 8'h00);
        chk("clrinc_ovf",   overflow,  1'b0);

        // Display 07, ones box pixel with opaque colour
        repeat (7) cyc(0, 0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1);
        chk("disp07_model", m_disp, 7);
        pixel_x  = 10'(X0 + 40);
        pixel_y  = 10'(Y0 + 5);
        video_on = 1'b1;
        rgb_bg   = 12'h123;
        #1;
        chk("d07_digit", rom_digit, 4'd7);
        chk("d07_row",   rom_row,   5'd5);
        chk("d07_col",   rom_col,   5'd8);
        step();
        cyc(0, 0, 1'b0, 12'h000, 12'h0F0, 1'b0, 1'b0, 1'b0);
        chk("d07_rgb", rgb_out, 12'h0F0);

        // Leading zero blanked, transparent ROM colour
        cyc(X0 + 3, Y0 + 3, 1'b1, 12'h456, 12'h000, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0);
        chk("lead_zero_rgb", rgb_out, 12'h456);
        cyc(X0 + 45, Y0 + 10, 1'b1, 12'h789, 12'h000, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 12'h000, 12'hFFF, 1'b0, 1'b0, 1'b0);
        chk("transp_rgb", rgb_out, 12'h789);

        // Field edges and blanking
        cyc(X0 - 1, Y0, 1'b1, 12'hABC, 12'h000, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 12'h000, 12'h0F0, 1'b0, 1'b0, 1'b0);
        chk("left_edge_rgb", rgb_out, 12'hABC);
        cyc(X0 + 64, Y0, 1'b1, 12'hDEF, 12'h000, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 12'h000, 12'h0F0, 1'b0, 1'b0, 1'b0);
        chk("right_edge_rgb", rgb_out, 12'hDEF);
        cyc(X0 + 40, Y0 + 5, 1'b0, 12'h321, 12'h000, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1'b0, 12'h000, 12'h0F0, 1'b0, 1'b0, 1'b0);
        chk("video_off_rgb", rgb_out, 12'h000);

        // Mid-line reset
        cyc(X0 + 40, Y0 + 5, 1'b1, 12'h222, 12'h0F0, 1'b1, 1'b0, 1'b0);
        cyc(X0 + 41, Y0 + 5, 1'b1, 12'h222, 12'h0F0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_rgb",   rgb_out,   12'h000);
        chk("midrst_score", score_bcd, 8'h00);
        chk("midrst_digit", rom_digit, 4'd0);
        step();
        reset_n = 1'b1;
        cyc(X0 + 42, Y0 + 5, 1'b1, 12'h333, 12'h0F0, 1'b1, 1'b0, 1'b0);
        cyc(X0 + 43, Y0 + 5, 1'b1, 12'h333, 12'h0F0, 1'b1, 1'b0, 1'b0);
        chk("postrst_rgb", rgb_out, 12'h0F0);
        chk("postrst_digit", rom_digit, 4'd0);
        cyc(X0 + 43, Y0 + 5, 1'b1, 12'h333, 12'h0F0, 1'b0, 1'b0, 1'b1);
        chk("postrst_tick_digit", rom_digit, 4'd2);

        // Randomized traffic with occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                chk("rand_rst_rgb", rgb_out, 12'h000);
                step();
                reset_n = 1'b1;
            end
            cyc(X0 - 8 + int'($urandom_range(0, 80)),
                Y0 - 4 + int'($urandom_range(0, 40)),
                $urandom_range(0, 9) != 0,
                12'($urandom),
                ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom),
                $urandom_range(0, 9) < 4,
                $urandom_range(0, 199) == 0,
                $urandom_range(0, 19) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
